// File: rtl/wb_spiflash.sv
// wb_spiflash: read-only Wishbone slave mapping an SPI NOR flash into the CPU address space.
// Each Wishbone read runs one READ (0x03) frame and returns one big-endian 32-bit word;
// writes are acknowledged without touching the flash.
//
// Handshake: a request is accepted when wb_cyc_i & wb_stb_i are high while wb_ack_o is low
// and the FSM is IDLE. wb_ack_o is a single-cycle pulse; a read whose master drops cyc/stb
// before the frame finishes completes on the SPI side but is neither acked nor stored.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   wb_adr_i [31:0]       byte address, bits [23:2] form the frame address
//   wb_dat_i [31:0]       write data (ignored)
//   wb_dat_o [31:0]       read data, held until the next completed read
//   wb_sel_i [3:0]        byte select (ignored)
//   wb_stb_i, wb_cyc_i    Wishbone strobe / cycle
//   wb_we_i               write enable
//   wb_ack_o              acknowledge pulse
//   spi_sck, spi_cs_n     SPI mode-0 clock and active-low chip select
//   spi_mosi, spi_miso    SPI data out / in
module wb_spiflash #(
    parameter int clk_div   = 2,   // SCK half-period in clk cycles (1..255)
    parameter int cs_gap    = 4,   // minimum cs_n high time between frames (1..255)
    parameter int adr_width = 24   // flash address bits carried in the frame
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        spi_sck,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        DONE,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(clk_div - 1);
    localparam logic [7:0] GAP_LAST = 8'(cs_gap - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q,   div_d;     // clk cycles spent in current phase
    logic [5:0]  bit_q,   bit_d;     // index of the bit sampled on the last SCK rise
    logic        sck_q,   sck_d;
    logic        cs_n_q,  cs_n_d;
    logic        ack_q,   ack_d;
    logic [63:0] tx_q,    tx_d;
    logic [31:0] rx_q,    rx_d;
    logic [31:0] dat_q,   dat_d;
    logic        req;

    // Write data, byte selects and address bits outside the frame are never used.
    logic unused_ok;
    assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:adr_width], wb_adr_i[1:0]};

    assign req      = wb_cyc_i & wb_stb_i;
    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign spi_sck  = sck_q;
    assign spi_cs_n = cs_n_q;
    // Command and address shift out MSB first; zeros fill in behind, so MOSI is 0 for the data phase.
    assign spi_mosi = tx_q[63];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            ack_q   <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            ack_q   <= ack_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dat_q   <= dat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        ack_d   = 1'b0;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dat_d   = dat_q;

        case (state_q)
            IDLE: begin
                if (req && !ack_q) begin
                    if (wb_we_i) begin
                        ack_d = 1'b1;
                    end else begin
                        tx_d    = {8'h03, wb_adr_i[adr_width-1:2], 2'b00, 32'h0};
                        cs_n_d  = 1'b0;
                        div_d   = '0;
                        bit_d   = '0;
                        state_d = SETUP;
                    end
                end
            end

            SETUP: begin
                if (div_q == DIV_LAST) begin
                    // Leaving setup is the first SCK rise: sample bit 0.
                    div_d   = '0;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[30:0], spi_miso};
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        tx_d  = {tx_q[62:0], 1'b0};
                    end else if (bit_q == 6'd63) begin
                        // Low half of the 64th period is over: frame complete.
                        cs_n_d  = 1'b1;
                        state_d = DONE;
                        if (req) begin
                            dat_d = rx_q;
                            ack_d = 1'b1;
                        end
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[30:0], spi_miso};
                        bit_d = bit_q + 6'd1;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            DONE: begin
                div_d   = '0;
                state_d = GAP;
            end

            GAP: begin
                if (div_q == GAP_LAST) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
